// File: rtl/recognizer_pkg.sv
// rtl/recognizer_pkg.sv - shared opcodes, response codes, FSM states and helpers
//   no ports: imported by recognizer_cmd_ctrl
package recognizer_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h00;
  localparam logic [7:0] CMD_COST  = 8'h01;
  localparam logic [7:0] CMD_START = 8'hFF;

  localparam logic [7:0] TX_BUSY = 8'hFF;
  localparam logic [7:0] TX_ERR  = 8'hFE;

  localparam int         IMG_BYTES = 72;
  localparam logic [3:0] MAX_LABEL = 4'd9;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ARM_LOAD    = 4'd1,
    LOADING     = 4'd2,
    LOADED      = 4'd3,
    COMPUTING   = 4'd4,
    DIGIT_READY = 4'd5,
    ARM_COST    = 4'd6,
    COSTING     = 4'd7,
    COST_READY  = 4'd8
  } ctrl_state_t;

  // Labels are decimal digits; anything larger saturates to the top digit.
  function automatic logic [3:0] clamp_label(input logic [7:0] b);
    return (b > 8'(MAX_LABEL)) ? MAX_LABEL : b[3:0];
  endfunction

endpackage

// File: rtl/frame_byte_counter.sv
// rtl/frame_byte_counter.sv - per-frame saturating byte index with first-byte flag
//   clk, n_rst           : clock, async active-low reset
//   rx_valid, frame_end  : byte strobe and end-of-frame strobe
//   byte_idx             : index of the byte arriving this cycle
//   byte_total           : bytes seen in this frame including this cycle's byte
//   first_byte           : rx_valid carries the first byte of the frame
module frame_byte_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rx_valid,
  input  logic             frame_end,
  output logic [CNT_W-1:0] byte_idx,
  output logic [CNT_W-1:0] byte_total,
  output logic             first_byte
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    byte_idx   = cnt_q;
    first_byte = rx_valid && (cnt_q == '0);
    // Saturate so an over-long frame can never wrap back to a valid length.
    byte_total = (rx_valid && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    // A byte sharing the cycle with frame_end is counted before the clear.
    cnt_d      = frame_end ? '0 : byte_total;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/recognizer_cmd_ctrl.sv
// rtl/recognizer_cmd_ctrl.sv - SPI command sequencer for the recognizer datapath
//   clk, n_rst                              : clock, async active-low reset
//   rx_data, rx_valid, frame_end            : SPI slave byte stream and frame boundary
//   img_we, img_addr, img_wdata             : image buffer write port
//   start_infer, infer_done, digit_in       : inference engine handshake
//   start_cost, cost_label, cost_done, cost_in : cost unit handshake
//   tx_data, busy                           : response byte for next frame, engines busy
module recognizer_cmd_ctrl #(
  parameter int WATCHDOG_CYCLES = 16384,
  parameter int ADDR_W          = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              frame_end,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              start_infer,
  input  logic              infer_done,
  input  logic [3:0]        digit_in,
  output logic              start_cost,
  output logic [3:0]        cost_label,
  input  logic              cost_done,
  input  logic [7:0]        cost_in,
  output logic [7:0]        tx_data,
  output logic              busy
);
  import recognizer_pkg::*;

  localparam int                WD_W    = $clog2(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IMG_CNT = ADDR_W'(IMG_BYTES);

  ctrl_state_t       state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic              img_we_q, img_we_d;
  logic [ADDR_W-1:0] img_addr_q, img_addr_d;
  logic [7:0]        img_wdata_q, img_wdata_d;
  logic              start_infer_q, start_infer_d;
  logic              start_cost_q, start_cost_d;
  logic [3:0]        cost_label_q, cost_label_d;
  logic              image_valid_q, image_valid_d;
  logic              digit_valid_q, digit_valid_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              cmd_vld_q, cmd_vld_d;

  logic [ADDR_W-1:0] byte_idx, byte_total;
  logic              first_byte;
  logic              busy_now, cmd_hit, cmd_now_vld;
  logic [7:0]        cmd_now;

  frame_byte_counter #(.CNT_W(ADDR_W)) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx_valid   (rx_valid),
    .frame_end  (frame_end),
    .byte_idx   (byte_idx),
    .byte_total (byte_total),
    .first_byte (first_byte)
  );

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    img_we_d      = 1'b0;
    img_addr_d    = img_addr_q;
    img_wdata_d   = img_wdata_q;
    start_infer_d = 1'b0;
    start_cost_d  = 1'b0;
    cost_label_d  = cost_label_q;
    image_valid_d = image_valid_q;
    digit_valid_d = digit_valid_q;
    cmd_d         = cmd_q;
    cmd_vld_d     = cmd_vld_q;

    busy_now = (state_q == COMPUTING) || (state_q == COSTING);
    wd_d     = busy_now ? wd_q + WD_W'(1) : '0;

    // The first byte of a frame is held until frame_end commits it; bytes
    // arriving while the engines run are never latched so they cannot act later.
    cmd_hit     = first_byte && !busy_now;
    cmd_now_vld = cmd_vld_q || cmd_hit;
    cmd_now     = cmd_vld_q ? cmd_q : rx_data;
    if (frame_end) begin
      cmd_vld_d = 1'b0;
    end else if (cmd_hit) begin
      cmd_vld_d = 1'b1;
      cmd_d     = rx_data;
    end

    case (state_q)
      IDLE, LOADED, DIGIT_READY, COST_READY: begin
        if (frame_end && cmd_now_vld) begin
          case (cmd_now)
            CMD_LOAD: begin
              state_d       = ARM_LOAD;
              image_valid_d = 1'b0;
              digit_valid_d = 1'b0;
            end
            CMD_START: begin
              // Outside LOADED this is a plain read of tx_data.
              if (state_q == LOADED && image_valid_q) begin
                start_infer_d = 1'b1;
                state_d       = COMPUTING;
                tx_d          = TX_BUSY;
              end
            end
            CMD_COST: begin
              if (digit_valid_q) state_d = ARM_COST;
              else               tx_d    = TX_BUSY;
            end
            default: ;
          endcase
        end
      end

      ARM_LOAD, LOADING: begin
        if (rx_valid) begin
          state_d = LOADING;
          if (byte_idx < IMG_CNT) begin
            img_we_d    = 1'b1;
            img_addr_d  = byte_idx;
            img_wdata_d = rx_data;
          end
        end
        // An empty frame while armed leaves us waiting for the image frame.
        if (frame_end && (state_q == LOADING || rx_valid)) begin
          if (byte_total >= IMG_CNT) begin
            image_valid_d = 1'b1;
            state_d       = LOADED;
          end else begin
            tx_d    = TX_ERR;
            state_d = IDLE;
          end
        end
      end

      ARM_COST: begin
        if (frame_end && cmd_now_vld) begin
          cost_label_d = clamp_label(cmd_now);
          start_cost_d = 1'b1;
          state_d      = COSTING;
          tx_d         = TX_BUSY;
        end
      end

      COMPUTING, COSTING: begin
        // A done strobe on the expiry cycle still delivers its result.
        if (state_q == COMPUTING && infer_done) begin
          tx_d          = {4'h0, digit_in};
          digit_valid_d = 1'b1;
          state_d       = DIGIT_READY;
        end else if (state_q == COSTING && cost_done) begin
          tx_d    = cost_in;
          state_d = COST_READY;
        end else if (wd_q == WD_LAST) begin
          tx_d          = TX_ERR;
          image_valid_d = 1'b0;
          digit_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      tx_q          <= 8'h00;
      img_we_q      <= 1'b0;
      img_addr_q    <= '0;
      img_wdata_q   <= 8'h00;
      start_infer_q <= 1'b0;
      start_cost_q  <= 1'b0;
      cost_label_q  <= 4'h0;
      image_valid_q <= 1'b0;
      digit_valid_q <= 1'b0;
      wd_q          <= '0;
      cmd_q         <= 8'h00;
      cmd_vld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      img_we_q      <= img_we_d;
      img_addr_q    <= img_addr_d;
      img_wdata_q   <= img_wdata_d;
      start_infer_q <= start_infer_d;
      start_cost_q  <= start_cost_d;
      cost_label_q  <= cost_label_d;
      image_valid_q <= image_valid_d;
      digit_valid_q <= digit_valid_d;
      wd_q          <= wd_d;
      cmd_q         <= cmd_d;
      cmd_vld_q     <= cmd_vld_d;
    end
  end

  assign img_we      = img_we_q;
  assign img_addr    = img_addr_q;
  assign img_wdata   = img_wdata_q;
  assign start_infer = start_infer_q;
  assign start_cost  = start_cost_q;
  assign cost_label  = cost_label_q;
  assign tx_data     = tx_q;
  assign busy        = (state_q == COMPUTING) || (state_q == COSTING);

endmodule
